// File: rtl/pump_scheduler_if.sv
// Command/status bundle between the mode controller and the pump session scheduler.
// The controller side issues start/abort pulses and selections; the scheduler side drives pump and LCD status.
interface pump_scheduler_if;
  logic       pump_on;
  logic       pump_off;
  logic [1:0] scent_sel;
  logic [1:0] timer_sel;
  logic [2:0] pump_en;
  logic       active;
  logic       spraying;
  logic [6:0] remain_min;
  logic       done;

  modport master (
    output pump_on, pump_off, scent_sel, timer_sel,
    input  pump_en, active, spraying, remain_min, done
  );

  modport slave (
    input  pump_on, pump_off, scent_sel, timer_sel,
    output pump_en, active, spraying, remain_min, done
  );
endinterface

// File: rtl/pump_scheduler.sv
// Timed spray/pause session scheduler for one of three scent pumps; outputs update one edge after the command.
// No backpressure: pump_on/pump_off are one-cycle pulses, acted on the edge they are sampled.
module pump_scheduler #(
  parameter int TICKS_PER_SEC = 1_000_000,
  parameter int SPRAY_SEC     = 5,
  parameter int INTERVAL_SEC  = 55
) (
  input logic             clk,
  input logic             reset,
  pump_scheduler_if.slave bus
);

  localparam int TW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int PMAX = (SPRAY_SEC > INTERVAL_SEC) ? SPRAY_SEC : INTERVAL_SEC;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] SPRAY_LAST = PW'(SPRAY_SEC - 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(INTERVAL_SEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPRAY = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [5:0]    sec_cnt, sec_nxt;
  logic [PW-1:0] phase_cnt, phase_nxt;
  logic [6:0]    remain, remain_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [2:0]    pump_en_nxt;
  logic          done_nxt;
  logic          sec_tick;
  logic          min_tick;
  logic [1:0]    scent_idx;
  logic [6:0]    load_min;

  assign sec_tick  = (tick_cnt == TICK_LAST);
  assign min_tick  = sec_tick && (sec_cnt == 6'd59);
  assign scent_idx = (bus.scent_sel == 2'd3) ? 2'd0 : bus.scent_sel;

  always_comb begin
    load_min = 7'd30;
    case (bus.timer_sel)
      2'd1:    load_min = 7'd60;
      2'd2:    load_min = 7'd120;
      default: load_min = 7'd30;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick_cnt;
    sec_nxt    = sec_cnt;
    phase_nxt  = phase_cnt;
    remain_nxt = remain;
    idx_nxt    = idx;
    done_nxt   = 1'b0;

    if (bus.pump_off) begin
      state_nxt  = IDLE;
      tick_nxt   = '0;
      sec_nxt    = '0;
      phase_nxt  = '0;
      remain_nxt = '0;
    end else if (bus.pump_on) begin
      state_nxt  = SPRAY;
      tick_nxt   = '0;
      sec_nxt    = '0;
      phase_nxt  = '0;
      remain_nxt = load_min;
      idx_nxt    = scent_idx;
    end else if (state != IDLE) begin
      tick_nxt = sec_tick ? '0 : tick_cnt + TW'(1);
      if (sec_tick) begin
        sec_nxt   = (sec_cnt == 6'd59) ? 6'd0 : sec_cnt + 6'd1;
        phase_nxt = phase_cnt + PW'(1);
      end
      if (min_tick) begin
        remain_nxt = remain - 7'd1;
      end
      // Expiry wins over a phase change landing on the same second.
      if (min_tick && remain == 7'd1) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        tick_nxt  = '0;
        sec_nxt   = '0;
        phase_nxt = '0;
      end else if (sec_tick) begin
        if (state == SPRAY && phase_cnt == SPRAY_LAST) begin
          state_nxt = PAUSE;
          phase_nxt = '0;
        end else if (state == PAUSE && phase_cnt == PAUSE_LAST) begin
          state_nxt = SPRAY;
          phase_nxt = '0;
          idx_nxt   = scent_idx;
        end
      end
    end

    pump_en_nxt = (state_nxt == SPRAY) ? (3'b001 << idx_nxt) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      sec_cnt      <= '0;
      phase_cnt    <= '0;
      remain       <= '0;
      idx          <= '0;
      bus.pump_en  <= 3'b000;
      bus.active   <= 1'b0;
      bus.spraying <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      state        <= state_nxt;
      tick_cnt     <= tick_nxt;
      sec_cnt      <= sec_nxt;
      phase_cnt    <= phase_nxt;
      remain       <= remain_nxt;
      idx          <= idx_nxt;
      bus.pump_en  <= pump_en_nxt;
      bus.active   <= (state_nxt != IDLE);
      bus.spraying <= (state_nxt == SPRAY);
      bus.done     <= done_nxt;
    end
  end

  assign bus.remain_min = remain;

endmodule

// File: tb/tb_pump_scheduler.sv
// Bench for pump_scheduler: a time-based session model (offset since start) is checked every cycle,
// with directed scenarios plus randomized selections and a random command soak.
module tb_pump_scheduler;

  localparam int T     = 4;
  localparam int S     = 2;
  localparam int I     = 3;
  localparam int SPR_C = S * T;
  localparam int CYC_C = (S + I) * T;
  localparam int MIN_C = 60 * T;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pump_scheduler_if ifc ();

  pump_scheduler #(
    .TICKS_PER_SEC(T),
    .SPRAY_SEC    (S),
    .INTERVAL_SEC (I)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int tests = 0;
  int fails = 0;

  // Model: a session is just "cycles since the start edge" plus the latched selections.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_e      = 0;
  int m_min    = 0;
  int m_idx    = 0;

  function automatic int load_of(input logic [1:0] t);
    return (t == 2'd1) ? 60 : (t == 2'd2) ? 120 : 30;
  endfunction

  function automatic int norm(input logic [1:0] s);
    return (s == 2'd3) ? 0 : int'(s);
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_all();
    bit         sp;
    logic [2:0] en;
    int         rem;
    sp  = m_active && ((m_e % CYC_C) < SPR_C);
    en  = sp ? 3'(1 << m_idx) : 3'b000;
    rem = m_active ? (m_min - m_e / MIN_C) : 0;
    chk("active",     8'(ifc.active),     8'(m_active));
    chk("spraying",   8'(ifc.spraying),   8'(sp));
    chk("pump_en",    8'(ifc.pump_en),    8'(en));
    chk("remain_min", 8'(ifc.remain_min), 8'(rem));
    chk("done",       8'(ifc.done),       8'(m_done));
  endtask

  task automatic tick();
    bit         pon, poff, rn;
    logic [1:0] sc, tm;
    pon  = ifc.pump_on;
    poff = ifc.pump_off;
    rn   = reset;
    sc   = ifc.scent_sel;
    tm   = ifc.timer_sel;
    @(posedge clk);
    m_done = 1'b0;
    if (!rn) begin
      m_active = 1'b0;
    end else if (poff) begin
      m_active = 1'b0;
    end else if (pon) begin
      m_active = 1'b1;
      m_e      = 0;
      m_min    = load_of(tm);
      m_idx    = norm(sc);
    end else if (m_active) begin
      m_e++;
      if (m_e == m_min * MIN_C) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else if (m_e % CYC_C == 0) begin
        m_idx = norm(sc);
      end
    end
    #1;
    check_all();
  endtask

  task automatic start(input logic [1:0] sc, input logic [1:0] tm);
    ifc.scent_sel = sc;
    ifc.timer_sel = tm;
    ifc.pump_on   = 1'b1;
    tick();
    ifc.pump_on   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int  done_at;
    bit  seen_done;

    reset         = 1'b0;
    ifc.pump_on   = 1'b0;
    ifc.pump_off  = 1'b0;
    ifc.scent_sel = 2'd0;
    ifc.timer_sel = 2'd0;

    // Reset and basic start.
    run(3);
    reset = 1'b1;
    run(3);
    start(2'd2, 2'd0);
    chk("start_pump_en", 8'(ifc.pump_en), 8'h04);
    chk("start_remain",  8'(ifc.remain_min), 8'd30);
    run(45);

    // Full 30-minute session with scent and timer wandering underneath.
    start(2'(($urandom) % 4), 2'd0);
    done_at   = 0;
    seen_done = 1'b0;
    for (int k = 1; k <= 7300 && !seen_done; k++) begin
      if ($urandom_range(0, 6) == 0) ifc.scent_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 50) == 0) ifc.timer_sel = 2'($urandom_range(0, 3));
      tick();
      if (k == 239) chk("remain_before_min", 8'(ifc.remain_min), 8'd30);
      if (k == 240) chk("remain_at_min",     8'(ifc.remain_min), 8'd29);
      if (ifc.done === 1'b1) begin
        seen_done = 1'b1;
        done_at   = k;
      end
    end
    chk("done_seen",   8'(seen_done), 8'd1);
    chk("done_cycle",  8'(done_at == 7200), 8'd1);
    run(5);
    chk("post_active", 8'(ifc.active),  8'd0);
    chk("post_pump",   8'(ifc.pump_en), 8'd0);

    // Abort mid-spray; no done afterwards (model expects done low each cycle).
    start(2'd1, 2'($urandom_range(0, 3)));
    run(4);
    ifc.pump_off = 1'b1;
    tick();
    ifc.pump_off = 1'b0;
    chk("abort_pump",   8'(ifc.pump_en),    8'd0);
    chk("abort_remain", 8'(ifc.remain_min), 8'd0);
    run(30);

    // Scent change lands only at the next spray.
    start(2'd0, 2'd1);
    run(3);
    ifc.scent_sel = 2'd1;
    run(4);
    chk("scent_hold", 8'(ifc.pump_en), 8'h01);
    run(13);
    chk("scent_next", 8'(ifc.pump_en), 8'h02);
    run(10);

    // Restart from PAUSE with 120 minutes, then coincident on/off.
    start(2'd2, 2'd0);
    run(10);
    chk("in_pause", 8'(ifc.spraying), 8'd0);
    start(2'd2, 2'd2);
    chk("restart_spray",  8'(ifc.spraying),   8'd1);
    chk("restart_remain", 8'(ifc.remain_min), 8'd120);
    run(25);
    ifc.pump_on  = 1'b1;
    ifc.pump_off = 1'b1;
    tick();
    ifc.pump_on  = 1'b0;
    ifc.pump_off = 1'b0;
    chk("onoff_idle", 8'(ifc.active), 8'd0);
    run(5);

    // Selection code 3 and synchronous reset mid-session.
    start(2'd3, 2'd3);
    chk("enc3_remain", 8'(ifc.remain_min), 8'd30);
    chk("enc3_pump",   8'(ifc.pump_en),    8'h01);
    run(50);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_active", 8'(ifc.active),     8'd0);
    chk("rst_remain", 8'(ifc.remain_min), 8'd0);
    run(5);

    // Random command soak.
    for (int k = 0; k < 1500; k++) begin
      ifc.pump_on   = ($urandom_range(0, 60) == 0);
      ifc.pump_off  = ($urandom_range(0, 150) == 0);
      ifc.scent_sel = 2'($urandom_range(0, 3));
      ifc.timer_sel = 2'($urandom_range(0, 3));
      reset         = ($urandom_range(0, 400) != 0);
      tick();
    end
    ifc.pump_on  = 1'b0;
    ifc.pump_off = 1'b0;
    reset        = 1'b1;
    run(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pump_scheduler.md
# pump_scheduler

Session scheduler for the diffuser pumps, sitting downstream of the button/UART mode controller. It accepts the controller's one-cycle `pump_on`/`pump_off` pulses plus its scent (`scent_sel`) and duration (`timer_sel`) selections. It then runs a timed session that alternates spray and pause phases on the one pump matching the selected scent. At the end of the session, or on abort, it returns all pumps to off and reports progress for the LCD.

## Interface
- `TICKS_PER_SEC`, default 1_000_000: `clk` cycles per second.
- `SPRAY_SEC`, default 5: spray phase length in seconds (≥1).
- `INTERVAL_SEC`, default 55: pause phase length in seconds (≥1).

- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-low.
- `pump_on` in 1: one-cycle pulse that starts or restarts a session.
- `pump_off` in 1: one-cycle pulse that aborts the session.
- `scent_sel` in 2: 0 = Cotton, 1 = Woody, 2 = Citrus, 3 = treated as 0.
- `timer_sel` in 2: 0 = 30 min, 1 = 60 min, 2 = 120 min, 3 = treated as 0.
- `pump_en` out 3: one-hot pump drive. Bit `scent_sel` is high only while in SPRAY.
- `active` out 1: high in SPRAY or PAUSE.
- `spraying` out 1: high in SPRAY.
- `remain_min` out 7: whole or partial minutes left in the session. Reads 0 in IDLE.
- `done` out 1: one-cycle pulse on natural session expiry. Not asserted on abort.

## Operation
- **States:** IDLE, SPRAY, PAUSE. All outputs are registered.
- **Counters:**
  - `tick_cnt` counts 0..TICKS_PER_SEC-1. Each wrap is a "second".
  - `sec_cnt` counts 0..59 seconds within the current minute.
  - `phase_cnt` counts seconds elapsed in the current phase.
  - `remain_min` is 7 bits, maximum 120.
- **IDLE + pump_on:**
  - Load `remain_min` with 30, 60 or 120 from `timer_sel`.
  - Clear `tick_cnt`, `sec_cnt` and `phase_cnt`.
  - Latch `scent_sel` into the pump index.
  - Go to SPRAY.
- **SPRAY:**
  - When `phase_cnt` reaches SPRAY_SEC at a second boundary, go to PAUSE and clear `phase_cnt`.
- **PAUSE:**
  - When `phase_cnt` reaches INTERVAL_SEC, go to SPRAY and clear `phase_cnt`.
  - Re-latch `scent_sel` on every PAUSE→SPRAY entry. A scent change mid-session therefore takes effect at the next spray, never mid-spray.
- **Minute boundary** (`sec_cnt` wraps 59→0): `remain_min` decrements.
  - If it decrements to 0: go to IDLE from either state, pulse `done`, and drop `pump_en`. This also applies mid-spray.
  - Expiry takes precedence over a phase transition in the same cycle.
- **pump_on while active:** restart. Behaves exactly like the IDLE + pump_on sequence: reload from the current `timer_sel`, clear all counters, re-latch scent, enter SPRAY. No `done` pulse.
- **pump_off in any state:** go to IDLE, `pump_en` = 0, `remain_min` = 0, counters cleared. In IDLE it has no effect.
- **Priority when signals coincide:** `reset` > `pump_off` > `pump_on` > expiry > phase transition.
- `timer_sel` changes during a session are ignored until the next `pump_on`.

## Timing
- **Reset values (after the cycle `reset` = 0 is sampled):**
  - State IDLE.
  - `pump_en` = 3'b000, `active` = 0, `spraying` = 0, `remain_min` = 0, `done` = 0.
  - All counters 0.
- **Start latency:** `pump_on` sampled at edge N gives, after edge N, `active` = `spraying` = 1, `pump_en` one-hot, and `remain_min` loaded.
- **Spray length:** exactly SPRAY_SEC × TICKS_PER_SEC cycles. Pause length: exactly INTERVAL_SEC × TICKS_PER_SEC cycles.
- **Session length:** exactly minutes × 60 × TICKS_PER_SEC cycles from the `pump_on` edge to the `done` edge. `done` is high for one cycle, coincident with `active` falling.
- **Abort latency:** `pump_off` at edge N gives `pump_en` = 0 after edge N.
- **Reset mid-session:** all outputs reach their reset values on the next edge. No `done`.

## Test plan
Test parameters: TICKS_PER_SEC = 4, SPRAY_SEC = 2, INTERVAL_SEC = 3.

1. **Reset and basic start.** Hold reset, release, then pulse `pump_on` with `scent_sel` = 2, `timer_sel` = 0.
   - Next cycle: `pump_en` = 3'b100, `remain_min` = 30.
   - `spraying` stays high for 8 cycles, then low for 12, repeating.
2. **Full session.** `timer_sel` = 0.
   - `done` pulses exactly 7200 cycles after `pump_on`.
   - `remain_min` steps 30→29 at cycle 240.
   - `active` = 0 and `pump_en` = 0 afterwards.
3. **Abort mid-spray.** `pump_off` at cycle 5 of a spray.
   - Next cycle: `pump_en` = 0, `remain_min` = 0.
   - `done` never pulses.
4. **Scent change.** Change `scent_sel` 0→1 during a spray.
   - `pump_en` stays 3'b001 until that spray ends.
   - The next spray drives 3'b010.
5. **Restart and coincident pulses.**
   - `pump_on` with `timer_sel` = 2 during PAUSE: immediate SPRAY, `remain_min` = 120.
   - `pump_on` and `pump_off` in the same cycle: IDLE.
6. **Encoding 3 and synchronous reset.**
   - `timer_sel` = 3 loads 30. `scent_sel` = 3 drives 3'b001.
   - Reset asserted mid-session: all outputs return to 0 on the next edge.
